// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, byte-enabled word bus,
// extended load results, word-crossing accesses split into two beats.
module load_store_unit #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [SIZE-1:0] req_addr,
  input  logic [SIZE-1:0] req_wdata,
  output logic            resp_valid,
  output logic [SIZE-1:0] resp_rdata,
  output logic            resp_error,
  output logic            mem_req,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [SIZE-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [SIZE-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic              split_q;
  logic [3:0]        be_hi_q;
  logic [SIZE-1:0]   wdata_q;
  logic [SIZE-1:0]   rd0_q;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [SIZE-1:0]   mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [SIZE-1:0]   mem_wdata_q;
  logic              resp_valid_q;
  logic [SIZE-1:0]   resp_rdata_q;
  logic              resp_error_q;

  logic [3:0]        in_mask;
  logic [2:0]        in_nb;
  logic [7:0]        in_be8;
  logic              in_split;
  logic [5:0]        hi_sh;

  always_comb begin
    in_mask = 4'b1111;
    in_nb   = 3'd4;
    unique case (req_size)
      2'b00: begin
        in_mask = 4'b0001;
        in_nb   = 3'd1;
      end
      2'b01: begin
        in_mask = 4'b0011;
        in_nb   = 3'd2;
      end
      default: ;
    endcase
    in_be8   = {4'b0000, in_mask} << req_addr[1:0];
    in_split = ({1'b0, req_addr[1:0]} + in_nb) > 3'd4;
  end

  // Second beat carries the bytes that spilled past the word boundary.
  assign hi_sh = {3'd4 - {1'b0, off_q}, 3'b000};

  function automatic logic [SIZE-1:0] merge(
    input logic [SIZE-1:0] lo,
    input logic [SIZE-1:0] hi
  );
    logic [SIZE-1:0] raw;
    logic [SIZE-1:0] res;
    raw = SIZE'({hi, lo} >> {off_q, 3'b000});
    unique case (size_q)
      2'b00:   res = {{24{~uns_q & raw[7]}}, raw[7:0]};
      2'b01:   res = {{16{~uns_q & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    if (write_q) res = '0;
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      split_q      <= 1'b0;
      be_hi_q      <= 4'b0000;
      wdata_q      <= '0;
      rd0_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[1:0];
            split_q <= in_split;
            be_hi_q <= in_be8[7:4];
            wdata_q <= req_wdata;
            if (req_size == 2'b11) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= BEAT0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_write;
              mem_addr_q  <= {req_addr[SIZE-1:2], 2'b00};
              mem_be_q    <= in_be8[3:0];
              mem_wdata_q <= req_wdata << {req_addr[1:0], 3'b000};
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            rd0_q     <= mem_rdata;
            mem_req_q <= 1'b0;
            if (split_q) begin
              state_q     <= BEAT1;
              mem_addr_q  <= mem_addr_q + SIZE'(4);
              mem_be_q    <= be_hi_q;
              mem_wdata_q <= wdata_q >> hi_sh;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b0;
              resp_rdata_q <= merge(mem_rdata, '0);
            end
          end
        end
        BEAT1: begin
          // First BEAT1 cycle is the mandatory low gap on mem_req.
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (mem_ack) begin
            mem_req_q    <= 1'b0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= merge(rd0_q, mem_rdata);
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          resp_rdata_q <= '0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
